// File: rtl/spr_rom_fetch.sv
// Sprite ROM fetch front-end: direct-mapped word cache in front of an SDRAM req/ack read port.
// Optional hit/miss statistics counters are compiled in with `define SPR_FETCH_STATS_EN.
module spr_rom_fetch #(
  parameter int                IDX_W  = 6,
  parameter int                SDR_AW = 24,
  parameter logic [SDR_AW-1:0] BASE   = 24'h080000
) (
  input  logic              clk,
  input  logic              nRES,
  input  logic [18:0]       spr_rom_addr,
  output logic [31:0]       spr_rom_dout,
  input  logic              ioctl_download,
  output logic              sdr_req,
  output logic [SDR_AW-1:0] sdr_addr,
  input  logic              sdr_ack,
  input  logic [31:0]       sdr_data,
  output logic              busy
`ifdef SPR_FETCH_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int AW    = 19;
  localparam int TAG_W = AW - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [AW-1:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]       dout_q, dout_d;
  logic              req_q, req_d;
  logic [SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
  logic              busy_q, busy_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic [IDX_W-1:0]  idx, f_idx;
  logic [TAG_W-1:0]  tag, f_tag;
  logic              hit;
  logic              mem_we;
  logic [SDR_AW-1:0] req_addr;

  assign idx      = addr_q[IDX_W-1:0];
  assign tag      = addr_q[AW-1:IDX_W];
  assign f_idx    = fetch_addr_q[IDX_W-1:0];
  assign f_tag    = fetch_addr_q[AW-1:IDX_W];
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  assign mem_we   = (state_q == S_FETCH) && sdr_ack;
  // Sum wraps modulo 2^SDR_AW by construction.
  assign req_addr = BASE + SDR_AW'(addr_q);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    dout_d       = dout_q;
    req_d        = req_q;
    sdr_addr_d   = sdr_addr_q;
    busy_d       = busy_q;
    valid_d      = ioctl_download ? '0 : valid_q;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          dout_d = data_mem[idx];
        end else if (!ioctl_download) begin
          fetch_addr_d = addr_q;
          req_d        = 1'b1;
          sdr_addr_d   = req_addr;
          busy_d       = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        // The fill lands even during a download; the clear above catches it next cycle.
        if (sdr_ack) begin
          valid_d[f_idx] = 1'b1;
          req_d          = 1'b0;
          busy_d         = 1'b0;
          state_d        = S_IDLE;
          if (addr_q == fetch_addr_q) begin
            dout_d = sdr_data;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      fetch_addr_q <= '0;
      dout_q       <= '0;
      req_q        <= 1'b0;
      sdr_addr_q   <= '0;
      busy_q       <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= spr_rom_addr;
      fetch_addr_q <= fetch_addr_d;
      dout_q       <= dout_d;
      req_q        <= req_d;
      sdr_addr_q   <= sdr_addr_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[f_idx] <= sdr_data;
      tag_mem[f_idx]  <= f_tag;
    end
  end

  assign spr_rom_dout = dout_q;
  assign sdr_req      = req_q;
  assign sdr_addr     = sdr_addr_q;
  assign busy         = busy_q;

`ifdef SPR_FETCH_STATS_EN
  logic [AW-1:0] prev_addr_q;
  logic [15:0]   hit_cnt_q, miss_cnt_q;
  logic          hit_evt, miss_evt;

  // A hit only counts when the sprite engine moved to a new address.
  assign hit_evt  = (state_q == S_IDLE) && hit && (addr_q != prev_addr_q);
  assign miss_evt = (state_q == S_IDLE) && !hit && !ioctl_download;

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      prev_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      prev_addr_q <= addr_q;
      if (ioctl_download) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        if (hit_evt && (hit_cnt_q != 16'hFFFF)) begin
          hit_cnt_q <= hit_cnt_q + 16'd1;
        end
        if (miss_evt && (miss_cnt_q != 16'hFFFF)) begin
          miss_cnt_q <= miss_cnt_q + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spr_rom_fetch.sv
// Directed self-checking bench for spr_rom_fetch; a second instance with BASE=24'hFFFFF0
// covers SDRAM address wrap and abandoned-request recovery across reset.
module tb_spr_rom_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRES;
  logic [18:0] spr_rom_addr, addr_w;
  logic [31:0] dout, w_dout;
  logic        ioctl_download;
  logic        req, w_req;
  logic [23:0] sa, w_sa;
  logic        ack, ack_w;
  logic [31:0] sdr_data;
  logic        busy, w_busy;
`ifdef SPR_FETCH_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, w_hit_cnt, w_miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  spr_rom_fetch dut (
    .clk            (clk),
    .nRES           (nRES),
    .spr_rom_addr   (spr_rom_addr),
    .spr_rom_dout   (dout),
    .ioctl_download (ioctl_download),
    .sdr_req        (req),
    .sdr_addr       (sa),
    .sdr_ack        (ack),
    .sdr_data       (sdr_data),
    .busy           (busy)
`ifdef SPR_FETCH_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  spr_rom_fetch #(.BASE(24'hFFFFF0)) dut_w (
    .clk            (clk),
    .nRES           (nRES),
    .spr_rom_addr   (addr_w),
    .spr_rom_dout   (w_dout),
    .ioctl_download (ioctl_download),
    .sdr_req        (w_req),
    .sdr_addr       (w_sa),
    .sdr_ack        (ack_w),
    .sdr_data       (sdr_data),
    .busy           (w_busy)
`ifdef SPR_FETCH_STATS_EN
    ,
    .hit_cnt        (w_hit_cnt),
    .miss_cnt       (w_miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ack(input logic [31:0] data);
    ack      = 1'b1;
    sdr_data = data;
    tick();
    ack      = 1'b0;
  endtask

`ifdef SPR_FETCH_STATS_EN
  logic [18:0] hit_seq [5];
`endif

  initial begin
    nRES           = 1'b0;
    spr_rom_addr   = 19'h00010;
    addr_w         = 19'h00020;
    ioctl_download = 1'b1;
    ack            = 1'b0;
    ack_w          = 1'b0;
    sdr_data       = 32'h0;
    #12;
    chk("rst_dout", dout, 32'h0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sdr_addr", {8'd0, sa}, 32'h0);

    // Hold download high through release so no request is made for the reset address.
    nRES = 1'b1;
    tick();
    chk("dl_no_req", {31'd0, req}, 32'd0);
    ioctl_download = 1'b0;
    tick();
    chk("miss_req", {31'd0, req}, 32'd1);
    chk("miss_sdr_addr", {8'd0, sa}, 32'h080010);
    chk("miss_busy", {31'd0, busy}, 32'd1);
    chk("wrap_req", {31'd0, w_req}, 32'd1);
    chk("wrap_sdr_addr", {8'd0, w_sa}, 32'h000010);
    tick();
    tick();
    chk("req_stable", {31'd0, req}, 32'd1);
    chk("addr_stable", {8'd0, sa}, 32'h080010);
    chk("dout_hold_busy", dout, 32'h0);
    fetch_ack(32'hDEADBEEF);
    chk("ack_fwd", dout, 32'hDEADBEEF);
    chk("ack_busy", {31'd0, busy}, 32'd0);
    chk("ack_req", {31'd0, req}, 32'd0);

    // Hit latency after visiting another line
    spr_rom_addr = 19'h00011;
    tick();
    tick();
    chk("miss2_sdr_addr", {8'd0, sa}, 32'h080011);
    fetch_ack(32'h22222222);
    chk("miss2_fwd", dout, 32'h22222222);
    spr_rom_addr = 19'h00010;
    tick();
    chk("hit_edge1_hold", dout, 32'h22222222);
    tick();
    chk("hit_edge2_data", dout, 32'hDEADBEEF);
    chk("hit_no_req", {31'd0, req}, 32'd0);

    // Conflicting tags on idx 6'h10
    spr_rom_addr = 19'h00050;
    tick();
    tick();
    chk("conf_a_sdr_addr", {8'd0, sa}, 32'h080050);
    fetch_ack(32'h50505050);
    spr_rom_addr = 19'h40010;
    tick();
    tick();
    chk("conf_b_req", {31'd0, req}, 32'd1);
    chk("conf_b_sdr_addr", {8'd0, sa}, 32'h0C0010);
    fetch_ack(32'h40404040);
    chk("conf_b_fwd", dout, 32'h40404040);
    spr_rom_addr = 19'h00010;
    tick();
    tick();
    chk("evicted_req", {31'd0, req}, 32'd1);
    chk("evicted_sdr_addr", {8'd0, sa}, 32'h080010);
    fetch_ack(32'hDEADBEEF);

    // Address moves during a fetch
    spr_rom_addr = 19'h00020;
    tick();
    tick();
    chk("mv_sdr_addr", {8'd0, sa}, 32'h080020);
    spr_rom_addr = 19'h00021;
    tick();
    chk("mv_req_held", {31'd0, req}, 32'd1);
    chk("mv_addr_held", {8'd0, sa}, 32'h080020);
    fetch_ack(32'h11111111);
    chk("mv_no_fwd", dout, 32'hDEADBEEF);
    chk("mv_req_low", {31'd0, req}, 32'd0);
    tick();
    chk("mv_new_req", {31'd0, req}, 32'd1);
    chk("mv_new_sdr_addr", {8'd0, sa}, 32'h080021);
    fetch_ack(32'h21212121);
    chk("mv_new_fwd", dout, 32'h21212121);
    spr_rom_addr = 19'h00020;
    tick();
    tick();
    chk("mv_line_filled", dout, 32'h11111111);
    chk("mv_line_no_req", {31'd0, req}, 32'd0);

    // Download invalidates the cache and suppresses requests
    ioctl_download = 1'b1;
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("inval_req", {31'd0, req}, 32'd1);
    chk("inval_sdr_addr", {8'd0, sa}, 32'h080020);
    fetch_ack(32'h20202020);
    chk("inval_fwd", dout, 32'h20202020);
    ioctl_download = 1'b1;
    spr_rom_addr   = 19'h00021;
    tick();
    tick();
    tick();
    chk("dl_held_no_req", {31'd0, req}, 32'd0);
    chk("dl_held_no_busy", {31'd0, busy}, 32'd0);
    chk("dl_held_dout", dout, 32'h20202020);
    ioctl_download = 1'b0;
    tick();
    chk("dl_release_req", {31'd0, req}, 32'd1);
    chk("dl_release_sdr_addr", {8'd0, sa}, 32'h080021);
    fetch_ack(32'h99999999);
    chk("dl_release_fwd", dout, 32'h99999999);

    // Reset while the wrap instance is still waiting for its ack
    chk("w_pending_req", {31'd0, w_req}, 32'd1);
    #3;
    nRES = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, w_req}, 32'd0);
    chk("async_rst_busy", {31'd0, w_busy}, 32'd0);
    chk("async_rst_dout", dout, 32'h0);
    ioctl_download = 1'b1;
    spr_rom_addr   = 19'h00100;
    nRES           = 1'b1;
    ack_w          = 1'b1;
    sdr_data       = 32'hBADBAD00;
    tick();
    ack_w = 1'b0;
    chk("stale_ack_dout", w_dout, 32'h0);
    chk("stale_ack_req", {31'd0, w_req}, 32'd0);
    chk("stale_ack_busy", {31'd0, w_busy}, 32'd0);
    tick();

`ifdef SPR_FETCH_STATS_EN
    chk("st_rst_hit", {16'd0, hit_cnt}, 32'd0);
    chk("st_rst_miss", {16'd0, miss_cnt}, 32'd0);
    ioctl_download = 1'b0;
    tick();
    fetch_ack(32'hA0000100);
    spr_rom_addr = 19'h00101;
    tick();
    tick();
    fetch_ack(32'hA0000101);
    spr_rom_addr = 19'h00102;
    tick();
    tick();
    fetch_ack(32'hA0000102);
    spr_rom_addr = 19'h00100;
    tick();
    hit_seq[0] = 19'h00101;
    hit_seq[1] = 19'h00102;
    hit_seq[2] = 19'h00100;
    hit_seq[3] = 19'h00101;
    hit_seq[4] = 19'h00101;
    for (int k = 0; k < 5; k++) begin
      spr_rom_addr = hit_seq[k];
      tick();
    end
    tick();
    chk("st_hit5", {16'd0, hit_cnt}, 32'd5);
    chk("st_miss3", {16'd0, miss_cnt}, 32'd3);
    for (int i = 0; i < 70000; i++) begin
      spr_rom_addr = i[0] ? 19'h00100 : 19'h00101;
      tick();
    end
    chk("st_hit_sat", {16'd0, hit_cnt}, 32'h0000FFFF);
    chk("st_miss_after_sat", {16'd0, miss_cnt}, 32'd3);
    ioctl_download = 1'b1;
    tick();
    chk("st_clr_hit", {16'd0, hit_cnt}, 32'd0);
    chk("st_clr_miss", {16'd0, miss_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spr_rom_fetch.md
Name: spr_rom_fetch

Overview:
- Sits between the sprite block's graphics ROM port and the shared SDRAM controller.
- Presents a ROM-like 32-bit read port: sprite address in, sprite data out.
- Services reads from a small direct-mapped word cache; on a miss it fetches over a req/ack SDRAM handshake.
- Hides SDRAM latency for the repeated row/column accesses the sprite engine makes during a line.

Parameters:
- IDX_W, 6, log2 of cache lines (64 lines of one 32-bit word each).
- SDR_AW, 24, SDRAM word-address width.
- BASE, 24'h080000, SDRAM word address of sprite ROM word 0.

Ports:
- clk  in  1  system clock.
- nRES  in  1  asynchronous active-low reset.
- spr_rom_addr  in  19  sprite ROM word address from the sprite block.
- spr_rom_dout  out  32  sprite ROM data to the sprite block (registered).
- ioctl_download  in  1  ROM download in progress.
- sdr_req  out  1  SDRAM read request, level.
- sdr_addr  out  SDR_AW  SDRAM word address.
- sdr_ack  in  1  one-cycle pulse; sdr_data valid in the same cycle.
- sdr_data  in  32  SDRAM read data.
- busy  out  1  high while a miss is outstanding.

Behaviour:
- Reset (nRES low, async): all outputs 0, addr_q=0, state IDLE, all valid bits cleared. Tag and data arrays are not reset.
- Every edge: addr_q <= spr_rom_addr.
- Lookup is on addr_q:
  - idx = addr_q[IDX_W-1:0].
  - tag = addr_q[18:IDX_W].
  - hit = valid[idx] & tag_mem[idx]==tag.
- State IDLE:
  - Hit: spr_rom_dout <= data_mem[idx] on the next edge. Hit latency is 2 edges from an spr_rom_addr change to new spr_rom_dout.
  - Miss with ioctl_download low: latch fetch_addr <= addr_q. Go to FETCH. sdr_req <= 1, sdr_addr <= BASE + zero-extended addr_q, truncated to SDR_AW bits (wrap-around allowed). busy <= 1.
  - Miss with ioctl_download high: no request; spr_rom_dout holds.
- State FETCH:
  - sdr_req and sdr_addr stay stable until sdr_ack.
  - On sdr_ack:
    - data_mem[fetch idx] <= sdr_data.
    - tag_mem[fetch idx] <= fetch tag.
    - valid <= 1.
    - sdr_req <= 0, busy <= 0. Return to IDLE.
    - If addr_q == fetch_addr in the ack cycle: spr_rom_dout <= sdr_data on the same edge.
    - Otherwise spr_rom_dout holds and IDLE performs a fresh lookup on the next cycle.
  - A fetch is never aborted by an address change.
  - sdr_ack seen while in IDLE is ignored.
- Minimum cycles between two requests: 1 IDLE cycle after the ack. sdr_req goes low for at least one cycle.
- ioctl_download high:
  - All valid bits are cleared every cycle.
  - An outstanding FETCH completes normally: ack accepted, data forwarded if matching. The line it writes is invalidated on the following cycle.
  - No new request is issued.
- Simultaneous download rise and ack: the ack completes the fetch; the invalidation still applies.
- Reset mid-FETCH: sdr_req drops asynchronously. The controller must tolerate the abandoned request; a later sdr_ack is ignored.
- spr_rom_dout holds its last value while busy; it never shows partial or garbage data.

Optional Feature:
- Macro: SPR_FETCH_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0 by nRES.
  - hit_cnt increments once per IDLE cycle with hit and a changed addr_q (addr_q != previous addr_q).
  - miss_cnt increments once per FETCH entry.
  - Both saturate at 16'hFFFF and clear while ioctl_download is high.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset → spr_rom_dout=0, sdr_req=0, busy=0. After release, spr_rom_addr=19'h00010 → sdr_req=1 with sdr_addr=24'h080010 on edge 2. Ack with sdr_data=32'hDEADBEEF three cycles later → spr_rom_dout=32'hDEADBEEF on the ack edge, busy=0.
- Same address re-presented after another address → hit: spr_rom_dout=32'hDEADBEEF two edges after the address change, sdr_req stays 0.
- Conflict: addr 19'h00050 then 19'h40010 (same idx 6'h10, different tag) → second access misses, sdr_addr=24'h0C0010. Re-reading 19'h00010 now misses.
- Address changes 19'h00020→19'h00021 during FETCH → ack data 32'h11111111 not driven to spr_rom_dout. A new request for 24'h080021 follows after one idle cycle with sdr_req low.
- ioctl_download pulse after lines are filled → all subsequent reads miss. With download held high, a miss raises no sdr_req. BASE=24'hFFFFF0 with addr 19'h00020 → sdr_addr=24'h000010 (wrap).
- SPR_FETCH_STATS_EN defined: 3 misses + 5 hits → miss_cnt=3, hit_cnt=5. Download pulse → both 0. 70000 forced hits → hit_cnt=16'hFFFF.
